rnd_stream_buffer: RTL and testbench
====================================

// Module: rnd_stream_buffer
// PURPOSE
//  Buffer between prng_top (producer) and the masked AES core's rnd_bus inputs (consumer).
//  Stores PRNG output words in a small FIFO.
//  Guarantees each random word reaches the core exactly once; a word is never reused.
//  Holds the core's randomness stream invalid until the FIFO has been primed full after reset.
//  Flags any consumer pop that finds no fresh randomness (underrun).
// PARAMETERS
//  RND    1024  width in bits of one random word (one core cycle's worth of rnd_bus bits)
//  DEPTH  4     FIFO depth in words; power of two, >=2
//  CW     $clog2(DEPTH+1)  width of the occupancy counter (derived, not overridden)
// PORTS
//  clk        in   1    single clock, rising edge
//  rst        in   1    asynchronous reset, active-high
//  in_rnd     in   RND  random word from the PRNG
//  in_valid   in   1    in_rnd valid (PRNG out_valid)
//  in_ready   out  1    buffer accepts in_rnd this cycle (drives PRNG out_ready)
//  out_rnd    out  RND  head word; sliced into rnd_bus0/2/3/4 by the integrator
//  out_valid  out  1    out_rnd holds fresh, never-consumed randomness
//  out_ready  in   1    consumer pops head this cycle (core advances a round step)
//  level      out  CW   current occupancy, 0..DEPTH
//  primed     out  1    FSM has reached RUN
//  underrun   out  1    sticky: pop attempted while out_valid was low
// BEHAVIOUR
//  Reset (async, rst=1): all storage=0, wr_ptr=rd_ptr=0, level=0, FSM=PRIME.
//   Outputs during and right after reset: in_ready=0 while rst=1, then 1; out_valid=0; out_rnd=0; primed=0; underrun=0.
//   rst asserted mid-operation discards all buffered words immediately; the FIFO must re-prime.
//  push = in_valid & in_ready. pop = out_ready & out_valid.
//  Both push and pop take effect on the rising edge.
//  in_ready = (level != DEPTH); registered-state only, no same-cycle bypass from pop.
//  Full: in_ready=0, so a push and a pop in the same cycle is impossible when full.
//  out_valid = primed & (level != 0). out_rnd = mem[rd_ptr], combinational from registers.
//  Latency: a word pushed at edge n appears on out_rnd after edge n when it is the head. No fall-through to out_rnd in the cycle it is presented.
//  On pop: mem[rd_ptr] <= 0 (consumed randomness is erased), and rd_ptr increments.
//  On push: mem[wr_ptr] <= in_rnd, and wr_ptr increments.
//  Pointers are log2(DEPTH) bits and wrap DEPTH-1 -> 0.
//  level: +1 on push only, -1 on pop only, unchanged on both or neither. Never exceeds DEPTH and never goes below 0.
//  FSM states:
//   PRIME: out_valid=0. Go to RUN when level==DEPTH, or when level==DEPTH-1 with a push this edge.
//   RUN: primed=1. Stays in RUN until reset; it does not re-enter PRIME when the FIFO empties.
//  Empty in RUN: out_valid=0, out_rnd=0.
//  Underrun: out_ready=1 while out_valid=0 in RUN sets underrun at the next edge. It holds until reset. State is otherwise unchanged.
//   out_ready during PRIME is ignored and does not flag underrun.
//  in_rnd is sampled only on push. Changes on in_rnd without in_valid have no effect.
// TESTING
//  T1 reset (RND=8, DEPTH=4): rst pulse -> out_valid=0, in_ready=1, level=0, primed=0, underrun=0, out_rnd=8'h00.
//  T2 prime: push 8'hA1,A2,A3 -> primed=0, out_valid=0.
//   Push 8'hA4 -> next cycle primed=1, out_valid=1, out_rnd=8'hA1, level=4, in_ready=0.
//  T3 order+erase: from T2, hold out_ready=1 for 4 cycles -> out_rnd reads A1,A2,A3,A4, then out_valid=0.
//   All mem words read 0, no underrun.
//  T4 simultaneous push/pop at level=2 -> level stays 2; order is preserved across pointer wrap after 6 pushes.
//  T5 underrun: in RUN with level=0, out_ready=1 -> underrun=1 next edge, stays 1 after later refills; level stays 0.
//  T6 reset mid-run: rst at level=3 -> level=0, primed=0, out_valid=0 asynchronously. Re-prime needs 4 fresh pushes.

Source files
------------

// File: rtl/rnd_stream_buffer.sv
// Randomness FIFO between the PRNG and the masked AES core: primes full after reset,
// hands out each word once, erases consumed words and flags pops that find no fresh data.
module rnd_stream_buffer #(
    parameter  int RND   = 1024,
    parameter  int DEPTH = 4,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [RND-1:0] in_rnd,
    input  logic           in_valid,
    output logic           in_ready,
    output logic [RND-1:0] out_rnd,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [CW-1:0]  level,
    output logic           primed,
    output logic           underrun
);

    localparam int PW = $clog2(DEPTH);

    typedef enum logic {
        PRIME = 1'b0,
        RUN   = 1'b1
    } state_e;

    state_e          state_q, state_d;
    logic [RND-1:0]  mem_q [DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   level_q, level_d;
    logic            underrun_q, underrun_d;
    logic            push, pop;

    // Readiness depends only on registered occupancy; a pop never frees a slot in the same cycle.
    assign in_ready  = ~rst & (level_q != CW'(DEPTH));
    assign out_valid = (state_q == RUN) & (level_q != '0);
    assign out_rnd   = mem_q[rd_ptr_q];
    assign level     = level_q;
    assign primed    = (state_q == RUN);
    assign underrun  = underrun_q;

    assign push = in_valid & in_ready;
    assign pop  = out_ready & out_valid;

    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        underrun_d = underrun_q;

        case (state_q)
            PRIME: begin
                if ((level_q == CW'(DEPTH)) || ((level_q == CW'(DEPTH - 1)) && push)) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (out_ready && !out_valid) begin
                    underrun_d = 1'b1;
                end
            end
            default: state_d = PRIME;
        endcase

        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (push && !pop) begin
            level_d = level_q + 1'b1;
        end else if (pop && !push) begin
            level_d = level_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= PRIME;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            underrun_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            underrun_q <= underrun_d;
        end
    end

    // Consumed words are wiped so spent randomness never lingers; push and pop never share a slot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (pop) begin
                mem_q[rd_ptr_q] <= '0;
            end
            if (push) begin
                mem_q[wr_ptr_q] <= in_rnd;
            end
        end
    end

endmodule

// File: tb/tb_rnd_stream_buffer.sv
// Bench for rnd_stream_buffer (RND=8, DEPTH=4): directed scenarios plus random traffic
// compared every cycle against a queue-based model of the buffer.
module tb_rnd_stream_buffer;

    localparam int RND   = 8;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [RND-1:0] in_rnd = '0;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [RND-1:0] out_rnd;
    logic           out_valid;
    logic           out_ready = 1'b0;
    logic [CW-1:0]  level;
    logic           primed;
    logic           underrun;

    int total = 0;
    int bad   = 0;

    logic [RND-1:0] mq[$];
    bit             m_primed   = 1'b0;
    bit             m_underrun = 1'b0;

    rnd_stream_buffer #(.RND(RND), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_rnd    (in_rnd),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_rnd   (out_rnd),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .level     (level),
        .primed    (primed),
        .underrun  (underrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all(input string tag);
        bit             exp_valid;
        logic [RND-1:0] exp_rnd;
        exp_valid = m_primed && (mq.size() != 0);
        exp_rnd   = (mq.size() != 0) ? mq[0] : '0;
        chk({tag, ".in_ready"},  32'(in_ready),  32'(!rst && mq.size() != DEPTH));
        chk({tag, ".out_valid"}, 32'(out_valid), 32'(exp_valid));
        chk({tag, ".out_rnd"},   32'(out_rnd),   32'(exp_rnd));
        chk({tag, ".level"},     32'(level),     32'(mq.size()));
        chk({tag, ".primed"},    32'(primed),    32'(m_primed));
        chk({tag, ".underrun"},  32'(underrun),  32'(m_underrun));
    endtask

    task automatic model_reset();
        mq.delete();
        m_primed   = 1'b0;
        m_underrun = 1'b0;
    endtask

    // One clock: drive inputs at the falling edge, let the edge happen, then compare.
    task automatic step(input string tag, input bit v, input logic [RND-1:0] d, input bit r);
        bit do_push, do_pop, go_run, flag;
        in_valid  = v;
        in_rnd    = d;
        out_ready = r;
        do_push = v && (mq.size() != DEPTH);
        do_pop  = r && m_primed && (mq.size() != 0);
        flag    = r && m_primed && (mq.size() == 0);
        go_run  = !m_primed && ((mq.size() == DEPTH) || (mq.size() == DEPTH - 1 && do_push));
        @(posedge clk);
        if (do_pop)  void'(mq.pop_front());
        if (do_push) mq.push_back(d);
        if (go_run)  m_primed = 1'b1;
        if (flag)    m_underrun = 1'b1;
        @(negedge clk);
        check_all(tag);
    endtask

    task automatic async_reset(input string tag);
        @(negedge clk);
        rst = 1'b1;
        #1;
        model_reset();
        check_all({tag, ".during"});
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_all({tag, ".after"});
    endtask

    initial begin
        // T1 reset
        in_valid = 1'b0;
        out_ready = 1'b0;
        #1;
        model_reset();
        check_all("t1_in_rst");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        check_all("t1_post");
        chk("t1_out_rnd_zero", 32'(out_rnd), 32'h0);
        chk("t1_in_ready", 32'(in_ready), 32'h1);

        // T2 prime
        step("t2_a1", 1'b1, 8'hA1, 1'b0);
        step("t2_a2", 1'b1, 8'hA2, 1'b0);
        step("t2_a3", 1'b1, 8'hA3, 1'b0);
        chk("t2_not_primed", 32'(primed), 32'h0);
        step("t2_a4", 1'b1, 8'hA4, 1'b0);
        chk("t2_primed", 32'(primed), 32'h1);
        chk("t2_head", 32'(out_rnd), 32'hA1);
        chk("t2_full", 32'(in_ready), 32'h0);
        step("t2_full_push_ignored", 1'b1, 8'h55, 1'b0);

        // T3 drain in order, consumed words erased
        chk("t3_h0", 32'(out_rnd), 32'hA1);
        step("t3_p1", 1'b0, 8'h00, 1'b1);
        chk("t3_h1", 32'(out_rnd), 32'hA2);
        step("t3_p2", 1'b0, 8'h00, 1'b0);
        step("t3_p2b", 1'b0, 8'h00, 1'b1);
        chk("t3_h2", 32'(out_rnd), 32'hA3);
        step("t3_p3", 1'b0, 8'h00, 1'b1);
        chk("t3_h3", 32'(out_rnd), 32'hA4);
        step("t3_p4", 1'b0, 8'h00, 1'b1);
        chk("t3_empty_valid", 32'(out_valid), 32'h0);
        for (int i = 0; i < DEPTH; i++) chk($sformatf("t3_mem%0d", i), 32'(dut.mem_q[i]), 32'h0);
        chk("t3_no_underrun", 32'(underrun), 32'h0);

        // T4 simultaneous push/pop at level 2, across pointer wrap
        step("t4_f1", 1'b1, 8'hB0, 1'b0);
        step("t4_f2", 1'b1, 8'hB1, 1'b0);
        for (int i = 0; i < 6; i++) begin
            step($sformatf("t4_pp%0d", i), 1'b1, 8'(8'hC0 + i), 1'b1);
            chk($sformatf("t4_lvl%0d", i), 32'(level), 32'h2);
        end

        // T5 underrun is sticky
        step("t5_d1", 1'b0, 8'h00, 1'b1);
        step("t5_d2", 1'b0, 8'h00, 1'b1);
        step("t5_under", 1'b0, 8'h00, 1'b1);
        chk("t5_flag", 32'(underrun), 32'h1);
        chk("t5_level0", 32'(level), 32'h0);
        step("t5_refill", 1'b1, 8'h77, 1'b0);
        step("t5_pop", 1'b0, 8'h00, 1'b1);
        chk("t5_still", 32'(underrun), 32'h1);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            step("rnd", ($urandom_range(0, 99) < 55), 8'($urandom), ($urandom_range(0, 99) < 50));
        end

        // T6 asynchronous reset at level 3, then re-prime
        for (int i = 0; i < DEPTH; i++) step("t6_drain", 1'b0, 8'h00, 1'b1);
        for (int i = 0; i < 3; i++) step("t6_fill", 1'b1, 8'(8'hD0 + i), 1'b0);
        chk("t6_level3", 32'(level), 32'h3);
        async_reset("t6_rst");
        for (int i = 0; i < 3; i++) step("t6_re", 1'b1, 8'(8'hE0 + i), 1'b1);
        chk("t6_not_primed", 32'(primed), 32'h0);
        step("t6_re4", 1'b1, 8'hE3, 1'b0);
        chk("t6_primed", 32'(primed), 32'h1);
        chk("t6_head", 32'(out_rnd), 32'hE0);

        // Random traffic after re-prime, including PRIME-phase pops
        async_reset("t7_rst");
        for (int i = 0; i < 300; i++) begin
            step("rnd2", ($urandom_range(0, 99) < 45), 8'($urandom), ($urandom_range(0, 99) < 60));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
